// File: rtl/startup_seq_pkg.sv
// rtl/startup_seq_pkg.sv - shared state encoding and widths for the startup sequencer
package startup_seq_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_PULSE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4,
        S_ERROR    = 3'd5
    } seq_state_e;

    function automatic logic is_busy_state(input logic [2:0] st);
        return (st == S_DELAY) || (st == S_PULSE) || (st == S_WAIT_ACK);
    endfunction

endpackage

// File: rtl/startup_sequencer_if.sv
// rtl/startup_sequencer_if.sv - control/status bundle between the start logic and the sequencer
interface startup_sequencer_if #(
    parameter int NSTAGE = 4,
    parameter int DLY_W  = 8
);
    localparam int SW = $clog2(NSTAGE);

    logic              start_i;
    logic              abort_i;
    logic [DLY_W-1:0]  stage_dly_i;
    logic [NSTAGE-1:0] stage_ack_i;
    logic [NSTAGE-1:0] stage_pulse_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic [SW-1:0]     err_stage_o;

    modport master (
        output start_i, abort_i, stage_dly_i, stage_ack_i,
        input  stage_pulse_o, busy_o, done_o, err_o, err_stage_o
    );

    modport slave (
        input  start_i, abort_i, stage_dly_i, stage_ack_i,
        output stage_pulse_o, busy_o, done_o, err_o, err_stage_o
    );

endinterface

// File: rtl/startup_sequencer_edge_det.sv
// rtl/startup_sequencer_edge_det.sv - rising-edge detector for the start level
module seq_edge_det (
    input  logic clk,
    input  logic reset_l,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;

    // Resetting to 0 means a level already high at release still reads as an edge.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/startup_sequencer.sv
// rtl/startup_sequencer.sv - ordered, delayed, acknowledged startup pulses to NSTAGE consumers
module startup_sequencer
    import startup_seq_pkg::*;
#(
    parameter int NSTAGE  = 4,
    parameter int DLY_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_l,
    startup_sequencer_if.slave bus
);
    localparam int SW = $clog2(NSTAGE);

    localparam logic [2:0] ST_IDLE     = S_IDLE;
    localparam logic [2:0] ST_DELAY    = S_DELAY;
    localparam logic [2:0] ST_PULSE    = S_PULSE;
    localparam logic [2:0] ST_WAIT_ACK = S_WAIT_ACK;
    localparam logic [2:0] ST_DONE     = S_DONE;
    localparam logic [2:0] ST_ERROR    = S_ERROR;

    localparam logic [SW-1:0]      LAST_STAGE = SW'(NSTAGE - 1);
    localparam logic [TIMER_W-1:0] TMO        = TIMER_W'(TIMEOUT);

    logic [2:0]         state_q, state_d;
    logic [SW-1:0]      stage_q, stage_d;
    logic [DLY_W-1:0]   cnt_q, cnt_d;
    logic [DLY_W-1:0]   dly_q, dly_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SW-1:0]      err_stage_q, err_stage_d;
    logic               start_rise;

    seq_edge_det u_start_edge (
        .clk     (clk),
        .reset_l (reset_l),
        .d_i     (bus.start_i),
        .rise_o  (start_rise)
    );

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        cnt_d       = cnt_q;
        dly_d       = dly_q;
        timer_d     = timer_q;
        err_stage_d = err_stage_q;

        if (bus.abort_i) begin
            state_d = ST_IDLE;
            stage_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_rise) begin
                        state_d = ST_DELAY;
                        stage_d = '0;
                        dly_d   = bus.stage_dly_i;
                        cnt_d   = bus.stage_dly_i;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == '0) begin
                        state_d = ST_PULSE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    state_d = ST_WAIT_ACK;
                    timer_d = '0;
                end
                ST_WAIT_ACK: begin
                    // An ack arriving on the final timer cycle still counts.
                    if (bus.stage_ack_i[stage_q]) begin
                        if (stage_q == LAST_STAGE) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DELAY;
                            stage_d = stage_q + 1'b1;
                            cnt_d   = dly_q;
                        end
                    end else if (timer_q == TMO) begin
                        state_d     = ST_ERROR;
                        err_stage_d = stage_q;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            stage_q     <= '0;
            cnt_q       <= '0;
            dly_q       <= '0;
            timer_q     <= '0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_q     <= stage_d;
            cnt_q       <= cnt_d;
            dly_q       <= dly_d;
            timer_q     <= timer_d;
            err_stage_q <= err_stage_d;
        end
    end

    // Everything below decodes registered state only, so outputs are glitch-free.
    assign bus.stage_pulse_o = (state_q == ST_PULSE)
                             ? ({{(NSTAGE-1){1'b0}}, 1'b1} << stage_q)
                             : '0;
    assign bus.busy_o        = is_busy_state(state_q);
    assign bus.done_o        = (state_q == ST_DONE);
    assign bus.err_o         = (state_q == ST_ERROR);
    assign bus.err_stage_o   = err_stage_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// tb/tb_startup_sequencer.sv - table-driven check of the startup sequencer
module tb_startup_sequencer;

    typedef struct {
        logic       st;
        logic       ab;
        logic [7:0] dly;
        logic [3:0] ack;
        logic [3:0] pulse;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] es;
    } vec_t;

    logic clk;
    logic reset_l;
    vec_t vq[$];
    int   n_vec;
    int   n_bad;
    logic       drv_start;
    logic [7:0] drv_dly;
    logic [1:0] cur_es;

    startup_sequencer_if #(.NSTAGE(4), .DLY_W(8)) bus ();

    startup_sequencer #(.NSTAGE(4), .DLY_W(8), .TIMEOUT(255)) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (bus)
    );

    wire [8:0] outs = {bus.stage_pulse_o, bus.busy_o, bus.done_o, bus.err_o, bus.err_stage_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got pulse=%b busy=%b done=%b err=%b es=%0d, want pulse=%b busy=%b done=%b err=%b es=%0d",
                     name, got[8:5], got[4], got[3], got[2], got[1:0],
                     want[8:5], want[4], want[3], want[2], want[1:0]);
        end
    endtask

    task automatic push(input logic s, input logic a, input logic [7:0] d, input logic [3:0] k,
                        input logic [3:0] p, input logic b, input logic dn, input logic er,
                        input logic [1:0] es);
        vec_t v;
        v.st = s; v.ab = a; v.dly = d; v.ack = k;
        v.pulse = p; v.busy = b; v.done = dn; v.err = er; v.es = es;
        vq.push_back(v);
    endtask

    // From the edge that entered DELAY: d DELAY cycles, the pulse, then into WAIT_ACK.
    task automatic stage_to_wait(input int stg, input int d, input logic [3:0] bg);
        logic [3:0] p;
        p = 4'b0001 << stg;
        for (int i = 0; i < d; i++) push(drv_start, 1'b0, drv_dly, bg, 4'b0, 1'b1, 1'b0, 1'b0, cur_es);
        push(drv_start, 1'b0, drv_dly, bg, p, 1'b1, 1'b0, 1'b0, cur_es);
        push(drv_start, 1'b0, drv_dly, bg, 4'b0, 1'b1, 1'b0, 1'b0, cur_es);
    endtask

    task automatic stage_seq(input int stg, input int d, input int wait_n,
                             input logic [3:0] bg, input logic [3:0] hit, input logic last);
        stage_to_wait(stg, d, bg);
        for (int i = 0; i < wait_n; i++) push(drv_start, 1'b0, drv_dly, bg, 4'b0, 1'b1, 1'b0, 1'b0, cur_es);
        push(drv_start, 1'b0, drv_dly, hit, 4'b0, ~last, last, 1'b0, cur_es);
    endtask

    task automatic stage_timeout(input int stg, input int d);
        stage_to_wait(stg, d, 4'b0);
        for (int i = 0; i < 255; i++) push(drv_start, 1'b0, drv_dly, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, cur_es);
        cur_es = 2'(stg);
        push(drv_start, 1'b0, drv_dly, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, cur_es);
    endtask

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            bus.start_i     = vq[i].st;
            bus.abort_i     = vq[i].ab;
            bus.stage_dly_i = vq[i].dly;
            bus.stage_ack_i = vq[i].ack;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), outs,
                  {vq[i].pulse, vq[i].busy, vq[i].done, vq[i].err, vq[i].es});
        end
        vq.delete();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cur_es = 2'd0;
        reset_l = 1'b0;
        bus.start_i = 1'b1;
        bus.abort_i = 1'b0;
        bus.stage_dly_i = 8'd0;
        bus.stage_ack_i = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs, 9'b0);
        reset_l = 1'b1;

        // Start held through reset, zero delay, start stays high afterwards.
        drv_start = 1'b1; drv_dly = 8'd0;
        push(1'b1, 1'b0, 8'd0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        for (int s = 0; s < 4; s++) stage_seq(s, 0, 0, 4'b0, 4'b0001 << s, s == 3);
        push(1'b1, 1'b0, 8'd0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        push(1'b1, 1'b0, 8'd0, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 2'd0);

        // Delay 3 captured at start, later dly input changes ignored, foreign acks ignored.
        push(1'b0, 1'b0, 8'd7, 4'b0, 4'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        push(1'b1, 1'b0, 8'd3, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drv_start = 1'b0; drv_dly = 8'd7;
        stage_seq(0, 3, 1, 4'b1110, 4'b0001, 1'b0);
        stage_seq(1, 3, 1, 4'b1101, 4'b0010, 1'b0);
        drv_start = 1'b1;
        stage_seq(2, 3, 1, 4'b1011, 4'b0100, 1'b0);
        drv_start = 1'b0;
        stage_seq(3, 3, 1, 4'b0111, 4'b1000, 1'b1);

        // Acks stuck high: the PULSE-cycle ack is ignored, first WAIT_ACK cycle advances.
        push(1'b1, 1'b0, 8'd1, 4'b1111, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drv_dly = 8'd1;
        for (int s = 0; s < 4; s++) stage_seq(s, 1, 0, 4'b1111, 4'b1111, s == 3);
        push(1'b0, 1'b1, 8'd1, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        // Ack on the last timer cycle wins; stage 2 then times out.
        push(1'b1, 1'b0, 8'd2, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drv_dly = 8'd2;
        stage_seq(0, 2, 255, 4'b0, 4'b0001, 1'b0);
        stage_seq(1, 2, 0, 4'b0, 4'b0010, 1'b0);
        stage_timeout(2, 2);
        for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 8'd2, 4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 2'd2);
        push(1'b1, 1'b0, 8'd2, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        stage_seq(0, 2, 0, 4'b0, 4'b0001, 1'b0);

        // Abort with a simultaneous start edge in stage 1 DELAY; restart only on a fresh edge.
        push(1'b1, 1'b1, 8'd2, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        push(1'b1, 1'b0, 8'd2, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        push(1'b1, 1'b0, 8'd2, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        push(1'b0, 1'b0, 8'd2, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        push(1'b1, 1'b0, 8'd2, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        stage_to_wait(0, 2, 4'b0);
        push(1'b0, 1'b0, 8'd2, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        push(1'b0, 1'b0, 8'd2, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd2);
        run_vectors("main");

        // Asynchronous reset between edges while in WAIT_ACK.
        #2;
        reset_l = 1'b0;
        #1;
        check("async_reset", outs, 9'b0);
        @(posedge clk);
        #1;
        check("held_reset", outs, 9'b0);
        reset_l = 1'b1;

        cur_es = 2'd0; drv_start = 1'b0; drv_dly = 8'd0;
        push(1'b1, 1'b0, 8'd0, 4'b0, 4'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        stage_seq(0, 0, 0, 4'b0, 4'b0001, 1'b0);
        stage_to_wait(1, 0, 4'b0);
        push(1'b0, 1'b1, 8'd0, 4'b0010, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        push(1'b0, 1'b0, 8'd0, 4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        run_vectors("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/startup_sequencer.md
Name: startup_sequencer

Overview:
- Generates an ordered series of single-cycle startup pulses to NSTAGE downstream consumers. Each pulse is separated by a programmable delay and gated by a per-stage acknowledge.
- Sits between the top-level start/reset logic and the blocks that need a guaranteed posedge after time zero.
- The start input is edge-detected against a register that resets to 0. A start held high through reset release therefore still produces exactly one sequence, so the startup edge is never lost.

Parameters:
- NSTAGE, 4, number of sequenced stages (2..16).
- DLY_W, 8, width of the inter-stage delay count.
- TIMEOUT, 255, maximum WAIT_ACK cycles before error (must fit in 16 bits).

Ports:
- clk  input  1  sole clock; all state changes on its posedge.
- reset_l  input  1  asynchronous, active-low reset.
- start_i  input  1  level; a 0->1 transition, as sampled, starts a sequence.
- abort_i  input  1  synchronous abort; highest priority.
- stage_dly_i  input  DLY_W  delay before each pulse; sampled at sequence start and held for the whole sequence.
- stage_ack_i  input  NSTAGE  per-stage acknowledge, level-sensitive.
- stage_pulse_o  output  NSTAGE  one-hot pulse to the active stage; zero otherwise.
- busy_o  output  1  high in DELAY, PULSE and WAIT_ACK.
- done_o  output  1  sticky; all stages acknowledged.
- err_o  output  1  sticky; an acknowledge timed out.
- err_stage_o  output  $clog2(NSTAGE)  index of the stage that timed out.

Behaviour:
- Reset (reset_l=0, asynchronous):
  - state=IDLE; start_q=0; stage=0; cnt=0; timer=0.
  - All outputs 0, err_stage_o=0.
- Start edge: start_rise = start_i & ~start_q. start_q <= start_i on every clock.
  - start_i high at reset release gives start_rise on the first posedge after release.
- States: IDLE, DELAY, PULSE, WAIT_ACK, DONE, ERROR.
- IDLE, DONE, ERROR: on start_rise:
  - clear done_o and err_o, stage=0, dly_q=stage_dly_i, cnt=stage_dly_i;
  - go to DELAY.
- DELAY: if cnt==0 go to PULSE, else cnt--.
  - With delay D, the pulse is high in the cycle after the (D+1)th posedge following the start-sampling edge.
- PULSE: stage_pulse_o[stage]=1 for exactly one cycle, decoded from registered state. Then go to WAIT_ACK with timer=0.
- WAIT_ACK: only stage_ack_i[stage] is examined. Other ack bits are ignored, and so is any ack seen during PULSE.
  - Ack and stage==NSTAGE-1: go to DONE, done_o=1.
  - Ack otherwise: stage++, cnt=dly_q, go to DELAY.
  - No ack and timer==TIMEOUT: go to ERROR, err_o=1, err_stage_o=stage.
  - No ack otherwise: timer++.
  - Ack in the same cycle that timer==TIMEOUT: the ack wins.
- start_rise while busy_o=1 is ignored. The sequence is not restarted.
- abort_i=1 in any state:
  - next state IDLE; done_o and err_o cleared; no pulse in the following cycle; stage=0.
  - abort_i beats a simultaneous start_rise. start_q still updates, so holding start high through an abort does not retrigger.
- done_o and err_o are never high together.
- Arithmetic: cnt is DLY_W bits, timer is 16 bits. Neither ever wraps, because each saturating compare happens before its increment or decrement.

Decomposition:
- Shared package startup_seq_pkg holds:
  - the state enum (3-bit encoding: IDLE=0, DELAY=1, PULSE=2, WAIT_ACK=3, DONE=4, ERROR=5);
  - the TIMER_W=16 constant.
- One natural sub-module, seq_edge_det: the start_q flop with rise output. It resets to 0 so the first-cycle edge is preserved.
- The FSM, counters and output decode live in startup_sequencer.

Test Plan:
- Hold start_i=1 through reset; release reset_l.
  - Expect stage_pulse_o=4'b0001 exactly once, 1 cycle after the first post-reset edge with stage_dly_i=0.
  - Expect no second sequence while start stays high.
- stage_dly_i=3, ack each stage 2 cycles after its pulse.
  - Expect pulses 0001, 0010, 0100, 1000, each 4 cycles after the previous ack was sampled.
  - Expect done_o=1 after the last ack; busy_o low afterwards.
- Never ack stage 2, TIMEOUT=255.
  - Expect err_o=1 and err_stage_o=2 256 cycles after stage 2 enters WAIT_ACK.
  - Expect stage_pulse_o to stay 0 afterwards; a new start edge clears err_o and restarts at stage 0.
- Assert stage_ack_i=4'b1111 permanently.
  - Expect an ack during PULSE to be ignored, each stage to advance on the first WAIT_ACK cycle, and done_o after 4 pulses.
- Assert abort_i together with start_rise mid-DELAY of stage 1.
  - Expect IDLE next cycle, no pulse, done_o=err_o=0, and no restart until start_i goes low then high.
- Assert reset_l low mid-WAIT_ACK between clock edges.
  - Expect all outputs 0 immediately (asynchronous).
  - Expect a fresh start after release to begin at stage 0.
